clock_period_checker: RTL and testbench

- Sits directly downstream of the clock high/low-time counter in the clk_fst domain.
- Pulses that counter's restart input, waits for its high-time/low-time outputs to settle, and derives the slow-clock period and high time.
- Compares the period against a programmed expected value and tolerance, then reports done/pass/timeout.
- Used after each MMCM DRP reconfiguration to confirm the new output frequency.

---
 rtl/clock_period_checker_pkg.sv | 30 +++
 rtl/clock_period_checker_period_stability_filter.sv | 62 ++++++
 rtl/clock_period_checker.sv | 180 ++++++++++++++++++
 tb/tb_clock_period_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_period_checker_pkg.sv
// Shared definitions for the clock period checker: FSM encoding, default
// count width and status-register bit layout.
package clock_period_checker_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESTART = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam int STAT_DONE_BIT    = 0;
   localparam int STAT_PASS_BIT    = 1;
   localparam int STAT_TIMEOUT_BIT = 2;

   function automatic logic [2:0] pack_status(input logic done_v,
                                              input logic pass_v,
                                              input logic timeout_v);
      logic [2:0] s;
      s                   = 3'b000;
      s[STAT_DONE_BIT]    = done_v;
      s[STAT_PASS_BIT]    = pass_v;
      s[STAT_TIMEOUT_BIT] = timeout_v;
      return s;
   endfunction

endpackage

// File: rtl/clock_period_checker_period_stability_filter.sv
// Tracks how many consecutive sampled cycles the period has stayed unchanged
// and flags when the run is long enough to evaluate.
module period_stability_filter
   import clock_period_checker_pkg::*;
#(
   parameter int PW            = CNT_W_DEFAULT + 1,
   parameter int STABLE_CYCLES = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          en_i,
   input  logic [PW-1:0] period_i,
   output logic          stable_o,
   output logic [PW-1:0] period_o
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);

   logic [PW-1:0]   prev_q, prev_d;
   logic [SC_W-1:0] cnt_q, cnt_d;
   logic            same_s;

   assign same_s   = (period_i == prev_q);
   assign stable_o = en_i && same_s && (cnt_q >= SC_W'(STABLE_CYCLES - 1));
   assign period_o = prev_q;

   // Next-state for the previous-period latch and the saturating run counter
   always_comb begin
      prev_d = prev_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         prev_d = '0;
         cnt_d  = '0;
      end else if (en_i) begin
         if (same_s) begin
            if (cnt_q != SC_W'(STABLE_CYCLES)) begin
               cnt_d = cnt_q + SC_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            cnt_d  = '0;
            prev_d = period_i;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= '0;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/clock_period_checker.sv
// Post-reconfiguration clock check: restarts the upstream high/low-time counter,
// waits for a stable period and grades it against the expected value.
module clock_period_checker
   import clock_period_checker_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEFAULT,
   parameter int STABLE_CYCLES  = 64,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int RESTART_CYCLES = 2
) (
   input  logic           clk_fst,
   input  logic           reset,
   input  logic           start,
   input  logic [CNT_W:0] exp_period,
   input  logic [CNT_W:0] tolerance,
   input  logic [CNT_W-1:0] ht_in,
   input  logic [CNT_W-1:0] lt_in,
   output logic           tester_restart,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic           timeout,
   output logic [CNT_W:0] period,
   output logic [CNT_W-1:0] high_time
);

   localparam int PW   = CNT_W + 1;
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W = $clog2(RESTART_CYCLES + 1);

   state_e           state_q, state_d;
   logic [PW-1:0]    exp_q, exp_d, tol_q, tol_d;
   logic [PW-1:0]    period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [RC_W-1:0]  rc_q, rc_d;
   logic             restart_q, restart_d;
   logic             done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;

   logic [PW-1:0]    period_now_s, dev_s, filt_period_s;
   logic             to_hit_s, stable_s;

   // Zero-extended sum can never wrap; deviation is always larger minus smaller
   assign period_now_s = {1'b0, ht_in} + {1'b0, lt_in};
   assign dev_s        = (period_now_s >= exp_q) ? (period_now_s - exp_q)
                                                 : (exp_q - period_now_s);
   assign to_hit_s     = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

   period_stability_filter #(
      .PW            (PW),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk_i    (clk_fst),
      .rst_i    (reset),
      .clear_i  (state_q == ST_RESTART),
      .en_i     (state_q == ST_SAMPLE),
      .period_i (period_now_s),
      .stable_o (stable_s),
      .period_o (filt_period_s)
   );

   assign tester_restart = restart_q;
   assign busy           = (state_q == ST_RESTART) || (state_q == ST_SETTLE) ||
                           (state_q == ST_SAMPLE);
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = timeout_q;
   assign period         = period_q;
   assign high_time      = high_q;

   // FSM next-state, timeout counting and result capture
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      tol_d     = tol_q;
      period_d  = period_q;
      high_d    = high_q;
      to_d      = to_q;
      rc_d      = rc_q;
      restart_d = restart_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RESTART;
               exp_d     = exp_period;
               tol_d     = tolerance;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               restart_d = 1'b1;
               rc_d      = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RESTART: begin
            to_d = '0;
            if (rc_q == RC_W'(RESTART_CYCLES - 1)) begin
               state_d   = ST_SETTLE;
               restart_d = 1'b0;
               rc_d      = '0;
            end else begin
               rc_d = rc_q + RC_W'(1);
            end
         end
         ST_SETTLE: begin
            to_d = to_q + TO_W'(1);
            if (to_hit_s) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               period_d  = period_now_s;
               high_d    = ht_in;
            end else if ((ht_in != '0) && (lt_in != '0)) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_SAMPLE: begin
            to_d = to_q + TO_W'(1);
            // Timeout wins over a stable evaluation landing on the same cycle
            if (to_hit_s) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               period_d  = period_now_s;
               high_d    = ht_in;
            end else if (stable_s) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b0;
               pass_d    = (dev_s <= tol_q);
               period_d  = filt_period_s;
               high_d    = ht_in;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge clk_fst or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         exp_q     <= '0;
         tol_q     <= '0;
         period_q  <= '0;
         high_q    <= '0;
         to_q      <= '0;
         rc_q      <= '0;
         restart_q <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         tol_q     <= tol_d;
         period_q  <= period_d;
         high_q    <= high_d;
         to_q      <= to_d;
         rc_q      <= rc_d;
         restart_q <= restart_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_clock_period_checker.sv
// Scoreboard bench for clock_period_checker: directed runs push expected
// results, a monitor compares them on each rising done.
module tb_clock_period_checker;

   localparam int CNT_W   = 16;
   localparam int STABLE  = 64;
   localparam int TMO     = 200;
   localparam int RST_C   = 2;
   localparam int LAT_OK  = 1 + RST_C + 2 + STABLE;
   localparam int LAT_TO  = 1 + RST_C + TMO;

   logic             clk_fst;
   logic             reset;
   logic             start;
   logic [CNT_W:0]   exp_period;
   logic [CNT_W:0]   tolerance;
   logic [CNT_W-1:0] ht_in;
   logic [CNT_W-1:0] lt_in;
   logic             tester_restart;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timeout;
   logic [CNT_W:0]   period;
   logic [CNT_W-1:0] high_time;

   clock_period_checker #(
      .CNT_W          (CNT_W),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO),
      .RESTART_CYCLES (RST_C)
   ) dut (
      .clk_fst        (clk_fst),
      .reset          (reset),
      .start          (start),
      .exp_period     (exp_period),
      .tolerance      (tolerance),
      .ht_in          (ht_in),
      .lt_in          (lt_in),
      .tester_restart (tester_restart),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .period         (period),
      .high_time      (high_time)
   );

   typedef struct {
      int p;
      int t;
      int per;
      int ht;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc    = 0;
   logic done_prev = 1'b0;

   initial clk_fst = 1'b0;
   always #5 clk_fst = ~clk_fst;

   always @(posedge clk_fst) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
   endtask

   task automatic push(input int p, input int t, input int per, input int ht, input int c);
      exp_t e;
      e.p = p; e.t = t; e.per = per; e.ht = ht; e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic go(input int e, input int tol, output int t0);
      exp_period = (CNT_W+1)'(e);
      tolerance  = (CNT_W+1)'(tol);
      start      = 1'b1;
      t0         = cyc;
      @(negedge clk_fst);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk_fst);
         n++;
      end
      chk("done_within_budget", int'(done === 1'b1), 1);
      @(negedge clk_fst);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_restart"}, tester_restart, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_high_time"}, high_time, 0);
   endtask

   task automatic chk_pulse(input string tag);
      chk({tag, "_restart_c1"}, tester_restart, 1);
      chk({tag, "_busy"}, busy, 1);
      @(negedge clk_fst);
      chk({tag, "_restart_c2"}, tester_restart, 1);
      @(negedge clk_fst);
      chk({tag, "_restart_off"}, tester_restart, 0);
   endtask

   // Monitor: compare each rising done against the oldest expectation
   always @(negedge clk_fst) begin
      exp_t e;
      if (done === 1'b1 && done_prev !== 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("pass", pass, e.p);
            chk("timeout", timeout, e.t);
            chk("period", period, e.per);
            chk("high_time", high_time, e.ht);
         end
      end
      done_prev = done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int t0;
      reset      = 1'b0;
      start      = 1'b0;
      exp_period = '0;
      tolerance  = '0;
      ht_in      = '0;
      lt_in      = '0;
      #2 reset = 1'b1;
      #1 chk_all_zero("reset_state");
      repeat (3) @(negedge clk_fst);
      reset = 1'b0;
      @(negedge clk_fst);

      // clk/8, exact match required
      ht_in = 16'd4; lt_in = 16'd4;
      go(8, 0, t0);
      push(1, 0, 8, 4, t0 + LAT_OK);
      chk_pulse("t1");
      wait_done(300);

      // clk/10 duty 3/7 against 8: tolerance 2 passes, 1 fails
      ht_in = 16'd3; lt_in = 16'd7;
      go(8, 2, t0);
      chk("done_cleared_by_start", done, 0);
      chk("busy_after_start", busy, 1);
      push(1, 0, 10, 3, t0 + LAT_OK);
      wait_done(300);
      go(8, 1, t0);
      push(0, 0, 10, 3, t0 + LAT_OK);
      wait_done(300);
      go(12, 2, t0);
      push(1, 0, 10, 3, t0 + LAT_OK);
      wait_done(300);
      go(9, 0, t0);
      push(0, 0, 10, 3, t0 + LAT_OK);
      wait_done(300);

      // stopped clock never leaves SETTLE
      ht_in = 16'd0; lt_in = 16'd0;
      go(8, 0, t0);
      push(0, 1, 0, 0, t0 + LAT_TO);
      wait_done(400);

      // period toggling 8/9 every 20 cycles never settles
      ht_in = 16'd4; lt_in = 16'd4;
      go(8, 0, t0);
      push(0, 1, 8, 4, t0 + LAT_TO);
      for (int k = 1; k <= 10; k++) begin
         while (cyc != t0 + 20 * k) @(negedge clk_fst);
         lt_in = (k % 2 == 1) ? 16'd5 : 16'd4;
      end
      wait_done(300);

      // toggling then steady 9: done 64 cycles after the last change
      ht_in = 16'd4; lt_in = 16'd4;
      go(9, 0, t0);
      push(1, 0, 9, 4, t0 + 60 + 65);
      for (int k = 1; k <= 3; k++) begin
         while (cyc != t0 + 20 * k) @(negedge clk_fst);
         lt_in = (k % 2 == 1) ? 16'd5 : 16'd4;
      end
      wait_done(300);

      // starts while busy are ignored
      lt_in = 16'd4;
      go(8, 0, t0);
      push(1, 0, 8, 4, t0 + LAT_OK);
      exp_period = 17'd100;
      start = 1'b1;
      @(negedge clk_fst);
      start = 1'b0;
      while (cyc != t0 + 30) @(negedge clk_fst);
      start = 1'b1;
      @(negedge clk_fst);
      start = 1'b0;
      wait_done(300);

      // reset during SAMPLE clears everything at once
      go(8, 0, t0);
      while (cyc != t0 + 30) @(negedge clk_fst);
      chk("busy_in_sample", busy, 1);
      reset = 1'b1;
      #1 chk_all_zero("reset_sample");
      @(negedge clk_fst);
      reset = 1'b0;
      @(negedge clk_fst);

      // reset during RESTART drops tester_restart immediately
      go(8, 0, t0);
      chk("restart_before_reset", tester_restart, 1);
      reset = 1'b1;
      #1 chk("restart_async_drop", tester_restart, 0);
      chk("busy_async_drop", busy, 0);
      @(negedge clk_fst);
      reset = 1'b0;
      @(negedge clk_fst);

      // fresh full sequence after reset
      go(8, 0, t0);
      push(1, 0, 8, 4, t0 + LAT_OK);
      chk_pulse("fresh");
      wait_done(300);

      repeat (2) @(negedge clk_fst);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
